// File: rtl/gated_event_window_counter.sv
// Counts rising edges of a registered gated signal over a programmable window of cycles
// and hands each window's count downstream through a valid/ready handshake.
module gated_event_window_counter #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             event_in,
    input  logic [WIN_W-1:0] win_len,
    output logic [CNT_W-1:0] out_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StHold
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e             state_q, state_d;
    logic               ev_q;
    logic [WIN_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               overflow_q, overflow_d;
    logic               out_valid_q, out_valid_d;
    logic               ev_rise;
    logic               start;

    assign ev_rise = event_in & ~ev_q;
    assign start   = en && (win_len != '0);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        out_count_d = out_count_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    timer_d = win_len;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = StCount;
                end
            end
            StCount: begin
                if (ev_rise) begin
                    if (count_q == CntMax) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                timer_d = timer_q - WIN_W'(1);
                // Last window cycle: its own edge is already folded into count_d/ovf_d.
                if (timer_q == WIN_W'(1)) begin
                    out_count_d = count_d;
                    overflow_d  = ovf_d;
                    out_valid_d = 1'b1;
                    state_d     = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (start) begin
                        timer_d = win_len;
                        count_d = '0;
                        ovf_d   = 1'b0;
                        state_d = StCount;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ev_q        <= 1'b0;
            timer_q     <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_count_q <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ev_q        <= event_in;
            timer_q     <= timer_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            out_count_q <= out_count_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_count = out_count_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == StCount);

endmodule

// File: tb/tb_gated_event_window_counter.sv
// Self-checking bench: directed window table, hand-written reset/zero-length sequences and
// randomized windows checked against an edge-counting reference model.
module tb_gated_event_window_counter;

    localparam int CW = 3;
    localparam int WW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          event_in;
    logic [WW-1:0] win_len;
    logic [CW-1:0] out_count;
    logic          out_valid;
    logic          out_ready;
    logic          overflow;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;
    int last_cnt = 0;
    int last_ovf = 0;

    typedef struct {
        int        len;
        bit        pre;
        bit [63:0] pat;
        bit        b2b;
        int        hold;
        int        exp_cnt;
        bit        exp_ovf;
    } vec_t;

    vec_t tbl[$];

    gated_event_window_counter #(
        .CNT_W(CW),
        .WIN_W(WW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .event_in (event_in),
        .win_len  (win_len),
        .out_count(out_count),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: rising edges in the level sequence pre, pat[0..len-1].
    function automatic int ref_edges(input bit pre, input bit [63:0] pat, input int len);
        int  n = 0;
        bit  p = pre;
        for (int i = 0; i < len; i++) begin
            if (pat[i] && !p) n++;
            p = pat[i];
        end
        return n;
    endfunction

    // Caller has set en/win_len/event_in for the start cycle (IDLE or HOLD handshake).
    task automatic do_window(input int len, input bit [63:0] pat, input int ec, input bit eo);
        cyc();
        out_ready = 1'b0;
        check("start_busy", busy, 1);
        for (int i = 0; i < len; i++) begin
            event_in = pat[i];
            en       = 1'($urandom);
            win_len  = WW'($urandom);
            cyc();
            if (i < len - 1) begin
                check("win_busy", busy, 1);
                check("win_valid_low", out_valid, 0);
            end
        end
        check("end_valid", out_valid, 1);
        check("end_busy", busy, 0);
        check("end_count", out_count, ec);
        check("end_ovf", overflow, eo);
        last_cnt = ec;
        last_ovf = eo;
    endtask

    task automatic run_vec(input vec_t v, input bit first);
        if (!first && v.b2b) begin
            out_ready = 1'b1;
        end else begin
            if (!first) begin
                out_ready = 1'b1;
                en        = 1'b0;
                cyc();
                check("to_idle_valid", out_valid, 0);
                check("to_idle_busy", busy, 0);
                check("kept_count", out_count, last_cnt);
                check("kept_ovf", overflow, last_ovf);
                out_ready = 1'b0;
            end
        end
        en       = 1'b1;
        win_len  = WW'(v.len);
        event_in = v.pre;
        do_window(v.len, v.pat, v.exp_cnt, v.exp_ovf);
        en        = 1'b0;
        out_ready = 1'b0;
        for (int h = 0; h < v.hold; h++) begin
            event_in = 1'($urandom);
            cyc();
            check("hold_valid", out_valid, 1);
            check("hold_count", out_count, last_cnt);
            check("hold_ovf", overflow, last_ovf);
            check("hold_busy", busy, 0);
        end
    endtask

    initial begin
        vec_t v;
        int   e;

        tbl.push_back('{10, 1'b0, 64'h2AA,   1'b0, 7, 5, 1'b0});
        tbl.push_back('{4,  1'b0, 64'hF,     1'b0, 0, 1, 1'b0});
        tbl.push_back('{4,  1'b1, 64'hF,     1'b1, 0, 0, 1'b0});
        tbl.push_back('{40, 1'b0, 64'h55555, 1'b0, 0, 7, 1'b1});
        tbl.push_back('{5,  1'b0, 64'hA,     1'b1, 0, 2, 1'b0});
        tbl.push_back('{3,  1'b0, 64'h4,     1'b0, 0, 1, 1'b0});
        tbl.push_back('{1,  1'b0, 64'h1,     1'b1, 0, 1, 1'b0});
        tbl.push_back('{8,  1'b0, 64'hFF,    1'b1, 3, 1, 1'b0});
        tbl.push_back('{12, 1'b1, 64'hFFF,   1'b1, 0, 0, 1'b0});

        reset     = 1'b1;
        en        = 1'b0;
        event_in  = 1'b0;
        out_ready = 1'b0;
        win_len   = '0;
        repeat (2) cyc();
        reset = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_count", out_count, 0);
        check("rst_ovf", overflow, 0);

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i == 0);

        for (int r = 0; r < 40; r++) begin
            v.len  = ($urandom_range(0, 4) == 0) ? $urandom_range(20, 64) : $urandom_range(1, 10);
            v.pat  = {$urandom, $urandom};
            v.pre  = 1'($urandom);
            v.b2b  = 1'($urandom);
            v.hold = $urandom_range(0, 3);
            e = ref_edges(v.pre, v.pat, v.len);
            v.exp_cnt = (e > CMAX) ? CMAX : e;
            v.exp_ovf = (e > CMAX);
            run_vec(v, 1'b0);
        end

        // Handshake with win_len=0, then idle with en high and zero length.
        out_ready = 1'b1;
        en        = 1'b1;
        win_len   = '0;
        cyc();
        out_ready = 1'b0;
        check("zero_hs_valid", out_valid, 0);
        check("zero_hs_busy", busy, 0);
        for (int k = 0; k < 5; k++) begin
            event_in = 1'($urandom);
            cyc();
            check("zero_idle_valid", out_valid, 0);
            check("zero_idle_busy", busy, 0);
        end
        en = 1'b0;

        // Known nonzero result so the reset clearing is observable.
        run_vec('{3, 1'b0, 64'h5, 1'b0, 0, 2, 1'b0}, 1'b1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // Reset mid-COUNT.
        en       = 1'b1;
        win_len  = WW'(10);
        event_in = 1'b0;
        cyc();
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            event_in = ~event_in;
            cyc();
        end
        check("midcnt_busy", busy, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("midcnt_rst_valid", out_valid, 0);
        check("midcnt_rst_busy", busy, 0);
        check("midcnt_rst_count", out_count, 0);
        check("midcnt_rst_ovf", overflow, 0);
        for (int k = 0; k < 12; k++) begin
            cyc();
            check("midcnt_no_result", out_valid, 0);
        end

        // Reset mid-HOLD.
        run_vec('{4, 1'b0, 64'h5, 1'b0, 0, 2, 1'b0}, 1'b1);
        cyc();
        check("midhold_valid", out_valid, 1);
        event_in = 1'b1;
        reset    = 1'b1;
        cyc();
        reset = 1'b0;
        check("midhold_rst_valid", out_valid, 0);
        check("midhold_rst_busy", busy, 0);
        check("midhold_rst_count", out_count, 0);
        check("midhold_rst_ovf", overflow, 0);

        // Fresh windows after reset: level high out of reset is consumed in IDLE.
        run_vec('{2, 1'b1, 64'h3, 1'b0, 0, 0, 1'b0}, 1'b1);
        run_vec('{3, 1'b0, 64'h4, 1'b1, 0, 1, 1'b0}, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gated_event_window_counter.md
Name: gated_event_window_counter

Overview:
- Downstream consumer of the registered gated-AND stage output: monitors its single-bit registered result and counts its rising edges over a programmable window of clock cycles.
- Presents each window's count to a downstream consumer with a valid/ready handshake.
- Used as a bench-visible activity monitor and as a rate check on the gated signal.

Parameters:
CNT_W, 8, width of event count and of out_count
WIN_W, 8, width of the window length input and internal timer

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-high reset
en  input  1  start/continue request; sampled only in IDLE and on handshake
event_in  input  1  registered gated signal from the upstream stage
win_len  input  WIN_W  window length in cycles; sampled when a window starts
out_count  output  CNT_W  rising-edge count of the completed window
out_valid  output  1  out_count/overflow valid
out_ready  input  1  downstream accepts result
overflow  output  1  count saturated during the reported window
busy  output  1  high in COUNT state

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - state=IDLE; out_count=0, out_valid=0, overflow=0, busy=0.
  - Internal count=0, timer=0, edge register ev_d=0.
  - Reset mid-window or mid-HOLD discards the window; no result is emitted.
- Edge detect:
  - ev_d <= event_in every cycle in all states.
  - edge = event_in & ~ev_d.
  - A level already high out of reset produces one edge on the first cycle after reset.
- IDLE:
  - busy=0, out_valid=0.
  - If en=1 and win_len!=0: timer<=win_len, count<=0, ovf<=0, go to COUNT next cycle.
  - If win_len==0: stay in IDLE, no result.
- COUNT:
  - busy=1. The window is exactly win_len cycles, starting with the first COUNT cycle.
  - Each cycle: if edge, count<=count+1, saturating at 2^CNT_W-1. An edge arriving while count is already at max sets ovf<=1, which is sticky for the window.
  - timer decrements each cycle.
  - On the cycle with timer==1 (the last window cycle), an edge in that cycle is included.
  - Next state is HOLD with out_count=final count, overflow=ovf, out_valid=1.
  - Latency: out_valid rises 1 cycle after the last window cycle.
  - en and win_len changes during COUNT are ignored.
- HOLD:
  - busy=0. out_valid, out_count and overflow are held stable until out_valid&out_ready.
  - Edges during HOLD are not counted. ev_d still tracks event_in, so a level held across the boundary does not produce a false edge.
  - On handshake with en=1 and win_len!=0: reload timer/count/ovf from current win_len, go to COUNT next cycle, out_valid=0 (gap of one HOLD→COUNT cycle, no window overlap).
  - On handshake otherwise: go to IDLE, out_valid=0.
  - out_ready while out_valid=0 has no effect.
- out_count and overflow keep their last reported values after the handshake until the next result.

Test Plan:
- Reset, en=1, win_len=10, event_in toggles 0/1 every cycle (5 rising edges in window), out_ready=1 -> out_valid pulses 1 cycle after window end, out_count=5, overflow=0.
- win_len=4, event_in held 1 from the window's first cycle -> out_count=1. In the next back-to-back window with the level still held -> out_count=0 (no false edge across HOLD).
- out_ready=0 for 7 cycles after out_valid -> out_valid, out_count and overflow stable all 7 cycles. Edges injected during HOLD are not counted in the next window.
- CNT_W=3, win_len=40, 10 rising edges -> out_count=7, overflow=1. The next window with 2 edges -> out_count=2, overflow=0.
- Edge on the last window cycle counted (win_len=3, single edge in cycle 3 -> out_count=1). win_len=0 with en=1 -> stays IDLE, out_valid never asserts.
- Reset asserted mid-COUNT and again mid-HOLD -> next cycle IDLE, out_valid=0, busy=0, out_count=0, overflow=0. A fresh window after reset counts from 0.
